// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: Tuse/Tnew codes,
// PC select codes, exception handler address and the mult/div FSM states.
package pipe_ctrl_pkg;

    localparam logic [1:0] TNONE = 2'd3;

    localparam logic [1:0] PC_SEL_SEQ     = 2'd0;
    localparam logic [1:0] PC_SEL_HANDLER = 2'd1;
    localparam logic [1:0] PC_SEL_EPC     = 2'd2;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // A source in D conflicts with a producer when the producer writes that
    // register and will not have the value ready before D needs it.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] wa,
        input logic [1:0] tnew
    );
        return (src == wa) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Tracks occupancy of the mult/div unit: loads a cycle count on a start pulse
// and holds busy until the count expires. Starts while running are ignored.
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      start,
    input  logic      is_div,
    output logic      busy,
    output md_state_e state_dbg
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        r_state <= MD_RUN;
                        r_cnt   <= is_div ? DIV_LOAD : MULT_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                MD_RUN: begin
                    if (r_cnt == '0) begin
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign state_dbg = r_state;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect controller for the 5-stage pipeline.
// Optional perf counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic [4:0]  e_wa,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  e_tnew,
    input  logic [1:0]  m_tnew,
    input  logic        d_is_md,
    input  logic        md_start_E,
    input  logic        md_is_div_E,
    input  logic        exc_req_M,
    input  logic        eret_M,
    output logic        en_PC_D,
    output logic        flush_E,
    output logic        flush_all,
    output logic [1:0]  pc_sel,
    output logic        md_busy
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    logic      w_stall_rs;
    logic      w_stall_rt;
    logic      w_stall_md;
    logic      w_stall;
    logic      w_md_start_ok;
    logic      w_md_busy;
    md_state_e w_md_state;

    // Register $0 is hard-wired, so it never creates a dependency.
    assign w_stall_rs = (d_rs != 5'd0) &&
                        (src_hazard(d_rs, d_tuse_rs, e_wa, e_tnew) ||
                         src_hazard(d_rs, d_tuse_rs, m_wa, m_tnew));
    assign w_stall_rt = (d_rt != 5'd0) &&
                        (src_hazard(d_rt, d_tuse_rt, e_wa, e_tnew) ||
                         src_hazard(d_rt, d_tuse_rt, m_wa, m_tnew));

    assign w_stall_md = d_is_md && ((w_md_state == MD_RUN) || md_start_E);
    assign w_stall    = w_stall_rs || w_stall_rt || w_stall_md;

    // The instruction in E is flushed by an exception, so its start is dropped.
    assign w_md_start_ok = md_start_E && !exc_req_M;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_timer (
        .clk       (clk),
        .reset     (reset),
        .start     (w_md_start_ok),
        .is_div    (md_is_div_E),
        .busy      (w_md_busy),
        .state_dbg (w_md_state)
    );

    assign md_busy = w_md_busy;

    always_comb begin
        en_PC_D   = !w_stall;
        flush_E   = w_stall;
        flush_all = 1'b0;
        pc_sel    = PC_SEL_SEQ;
        if (exc_req_M) begin
            en_PC_D   = 1'b1;
            flush_E   = 1'b1;
            flush_all = 1'b1;
            pc_sel    = PC_SEL_HANDLER;
        end else if (eret_M) begin
            en_PC_D   = 1'b1;
            flush_E   = 1'b1;
            flush_all = 1'b1;
            pc_sel    = PC_SEL_EPC;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (!en_PC_D)
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            if (flush_all)
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
    assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule
